// File: rtl/axi_lite_reg_slice.sv
// Registered AXI4-Lite slice: every channel passes through a two-entry skid buffer.
// Latency: one clock per direction; sustains one beat per clock per channel.
// Backpressure: input ready comes straight from a flop and drops once the skid entry is occupied.

// Generic two-entry skid buffer; state bits double as the out_vld / !in_rdy flops.
module axi_lite_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    // Encoding chosen so bit 0 is out_vld and bit 1 is skid occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] skid_dat_q;
    logic             in_hs, out_hs;
    logic             load_out_in, load_out_skid, load_skid;

    assign out_vld = state_q[0];
    assign in_rdy  = ~state_q[1];
    assign in_hs   = in_vld & in_rdy;
    assign out_hs  = out_vld & out_rdy;

    // Next state and register load enables from the two handshakes.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d     = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_out_in = 1'b1;
                end else if (in_hs) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    state_d       = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; reset discards any held beats.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; out_dat only changes on a load so it is stable while stalled.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            out_dat    <= '0;
            skid_dat_q <= '0;
        end else begin
            if (load_out_in) begin
                out_dat <= in_dat;
            end else if (load_out_skid) begin
                out_dat <= skid_dat_q;
            end
            if (load_skid) begin
                skid_dat_q <= in_dat;
            end
        end
    end

endmodule

module axi_lite_reg_slice #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    // Bus master side
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [2:0]              S_AXI_awprot,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [2:0]              S_AXI_arprot,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready,
    // MMIO subsystem side
    output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
    output logic [2:0]              M_AXI_awprot,
    output logic                    M_AXI_awvalid,
    input  logic                    M_AXI_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
    output logic                    M_AXI_wvalid,
    input  logic                    M_AXI_wready,
    input  logic [1:0]              M_AXI_bresp,
    input  logic                    M_AXI_bvalid,
    output logic                    M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
    output logic [2:0]              M_AXI_arprot,
    output logic                    M_AXI_arvalid,
    input  logic                    M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
    input  logic [1:0]              M_AXI_rresp,
    input  logic                    M_AXI_rvalid,
    output logic                    M_AXI_rready
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            prot;
    } ax_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
    } w_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
    } r_t;

    ax_t        aw_in, aw_out, ar_in, ar_out;
    w_t         w_in, w_out;
    r_t         r_in, r_out;
    logic [1:0] b_out;

    assign aw_in = '{addr: S_AXI_awaddr, prot: S_AXI_awprot};
    assign ar_in = '{addr: S_AXI_araddr, prot: S_AXI_arprot};
    assign w_in  = '{data: S_AXI_wdata,  strb: S_AXI_wstrb};
    assign r_in  = '{data: M_AXI_rdata,  resp: M_AXI_rresp};

    assign M_AXI_awaddr = aw_out.addr;
    assign M_AXI_awprot = aw_out.prot;
    assign M_AXI_araddr = ar_out.addr;
    assign M_AXI_arprot = ar_out.prot;
    assign M_AXI_wdata  = w_out.data;
    assign M_AXI_wstrb  = w_out.strb;
    assign S_AXI_rdata  = r_out.data;
    assign S_AXI_rresp  = r_out.resp;
    assign S_AXI_bresp  = b_out;

    axi_lite_skid_buf #(.WIDTH($bits(ax_t))) u_aw (
        .aclk(aclk), .arst_n(arst_n),
        .in_vld(S_AXI_awvalid), .in_rdy(S_AXI_awready), .in_dat(aw_in),
        .out_vld(M_AXI_awvalid), .out_rdy(M_AXI_awready), .out_dat(aw_out)
    );

    axi_lite_skid_buf #(.WIDTH($bits(w_t))) u_w (
        .aclk(aclk), .arst_n(arst_n),
        .in_vld(S_AXI_wvalid), .in_rdy(S_AXI_wready), .in_dat(w_in),
        .out_vld(M_AXI_wvalid), .out_rdy(M_AXI_wready), .out_dat(w_out)
    );

    axi_lite_skid_buf #(.WIDTH(2)) u_b (
        .aclk(aclk), .arst_n(arst_n),
        .in_vld(M_AXI_bvalid), .in_rdy(M_AXI_bready), .in_dat(M_AXI_bresp),
        .out_vld(S_AXI_bvalid), .out_rdy(S_AXI_bready), .out_dat(b_out)
    );

    axi_lite_skid_buf #(.WIDTH($bits(ax_t))) u_ar (
        .aclk(aclk), .arst_n(arst_n),
        .in_vld(S_AXI_arvalid), .in_rdy(S_AXI_arready), .in_dat(ar_in),
        .out_vld(M_AXI_arvalid), .out_rdy(M_AXI_arready), .out_dat(ar_out)
    );

    axi_lite_skid_buf #(.WIDTH($bits(r_t))) u_r (
        .aclk(aclk), .arst_n(arst_n),
        .in_vld(M_AXI_rvalid), .in_rdy(M_AXI_rready), .in_dat(r_in),
        .out_vld(S_AXI_rvalid), .out_rdy(S_AXI_rready), .out_dat(r_out)
    );

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
module tb_axi_lite_reg_slice;

    logic        aclk = 1'b0;
    logic        arst_n;
    logic [15:0] S_AXI_awaddr;  logic [2:0] S_AXI_awprot;  logic S_AXI_awvalid, S_AXI_awready;
    logic [31:0] S_AXI_wdata;   logic [3:0] S_AXI_wstrb;   logic S_AXI_wvalid,  S_AXI_wready;
    logic [1:0]  S_AXI_bresp;   logic S_AXI_bvalid, S_AXI_bready;
    logic [15:0] S_AXI_araddr;  logic [2:0] S_AXI_arprot;  logic S_AXI_arvalid, S_AXI_arready;
    logic [31:0] S_AXI_rdata;   logic [1:0] S_AXI_rresp;   logic S_AXI_rvalid,  S_AXI_rready;
    logic [15:0] M_AXI_awaddr;  logic [2:0] M_AXI_awprot;  logic M_AXI_awvalid, M_AXI_awready;
    logic [31:0] M_AXI_wdata;   logic [3:0] M_AXI_wstrb;   logic M_AXI_wvalid,  M_AXI_wready;
    logic [1:0]  M_AXI_bresp;   logic M_AXI_bvalid, M_AXI_bready;
    logic [15:0] M_AXI_araddr;  logic [2:0] M_AXI_arprot;  logic M_AXI_arvalid, M_AXI_arready;
    logic [31:0] M_AXI_rdata;   logic [1:0] M_AXI_rresp;   logic M_AXI_rvalid,  M_AXI_rready;

    int checks = 0;
    int errors = 0;

    // Channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R. Model: each channel is an ordered
    // container holding at most two beats that have been accepted but not yet delivered.
    logic [63:0] mq [5][$];
    int          ch_width [5] = '{19, 36, 19, 2, 34};

    axi_lite_reg_slice #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
        .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
        .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
        .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
    );

    always #5 aclk = ~aclk;

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic drive(input int ch, input logic v, input logic [63:0] d, input logic r);
        case (ch)
            0: begin S_AXI_awvalid = v; {S_AXI_awaddr, S_AXI_awprot} = d[18:0]; M_AXI_awready = r; end
            1: begin S_AXI_wvalid  = v; {S_AXI_wdata, S_AXI_wstrb}   = d[35:0]; M_AXI_wready  = r; end
            2: begin S_AXI_arvalid = v; {S_AXI_araddr, S_AXI_arprot} = d[18:0]; M_AXI_arready = r; end
            3: begin M_AXI_bvalid  = v; M_AXI_bresp = d[1:0];                   S_AXI_bready  = r; end
            default: begin M_AXI_rvalid = v; {M_AXI_rdata, M_AXI_rresp} = d[33:0]; S_AXI_rready = r; end
        endcase
    endtask

    task automatic idle_inputs();
        for (int c = 0; c < 5; c++) drive(c, 1'b0, 64'd0, 1'b1);
    endtask

    function automatic logic obs_vld(input int ch);
        case (ch)
            0: return M_AXI_awvalid;
            1: return M_AXI_wvalid;
            2: return M_AXI_arvalid;
            3: return S_AXI_bvalid;
            default: return S_AXI_rvalid;
        endcase
    endfunction

    function automatic logic obs_rdy(input int ch);
        case (ch)
            0: return S_AXI_awready;
            1: return S_AXI_wready;
            2: return S_AXI_arready;
            3: return M_AXI_bready;
            default: return M_AXI_rready;
        endcase
    endfunction

    function automatic logic [63:0] obs_dat(input int ch);
        case (ch)
            0: return {45'd0, M_AXI_awaddr, M_AXI_awprot};
            1: return {28'd0, M_AXI_wdata, M_AXI_wstrb};
            2: return {45'd0, M_AXI_araddr, M_AXI_arprot};
            3: return {62'd0, S_AXI_bresp};
            default: return {30'd0, S_AXI_rdata, S_AXI_rresp};
        endcase
    endfunction

    task automatic test_reset();
        arst_n = 1'b0;
        idle_inputs();
        #12;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs_vld(c) !== 1'b0) begin errors++; $display("FAIL reset_valid ch%0d: got %b want 0", c, obs_vld(c)); end
            checks++;
            if (obs_rdy(c) !== 1'b1) begin errors++; $display("FAIL reset_ready ch%0d: got %b want 1", c, obs_rdy(c)); end
            checks++;
            if (obs_dat(c) !== 64'd0) begin errors++; $display("FAIL reset_data ch%0d: got %h want 0", c, obs_dat(c)); end
        end
        step();
        arst_n = 1'b1;
    endtask

    task automatic test_single_write();
        // cycle 0
        S_AXI_awvalid = 1'b1; S_AXI_awaddr = 16'h0004; S_AXI_awprot = 3'd0;
        S_AXI_wvalid  = 1'b1; S_AXI_wdata  = 32'hDEAD_BEEF; S_AXI_wstrb = 4'hF;
        step(); // cycle 1
        S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_wdata = 32'h0; S_AXI_awaddr = 16'hFFFF;
        sample();
        checks++;
        if (M_AXI_awvalid !== 1'b1 || M_AXI_awaddr !== 16'h0004 || M_AXI_awprot !== 3'd0) begin
            errors++; $display("FAIL wr_aw_cycle1: got v=%b a=%h p=%0d want v=1 a=0004 p=0", M_AXI_awvalid, M_AXI_awaddr, M_AXI_awprot);
        end
        checks++;
        if (M_AXI_wvalid !== 1'b1 || M_AXI_wdata !== 32'hDEAD_BEEF || M_AXI_wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_w_cycle1: got v=%b d=%h s=%h want v=1 d=deadbeef s=f", M_AXI_wvalid, M_AXI_wdata, M_AXI_wstrb);
        end
        step(); // cycle 2
        sample();
        checks++;
        if (M_AXI_awvalid !== 1'b0 || M_AXI_wvalid !== 1'b0) begin
            errors++; $display("FAIL wr_no_dup: got awv=%b wv=%b want 0 0", M_AXI_awvalid, M_AXI_wvalid);
        end
        step(); // cycle 3
        M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b00;
        sample();
        checks++;
        if (M_AXI_bready !== 1'b1) begin errors++; $display("FAIL wr_bready: got %b want 1", M_AXI_bready); end
        step(); // cycle 4
        M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b11;
        sample();
        checks++;
        if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== 2'b00) begin
            errors++; $display("FAIL wr_b_cycle4: got v=%b r=%b want v=1 r=00", S_AXI_bvalid, S_AXI_bresp);
        end
        step(); // cycle 5
        sample();
        checks++;
        if (S_AXI_bvalid !== 1'b0) begin errors++; $display("FAIL wr_b_done: got %b want 0", S_AXI_bvalid); end
        step();
    endtask

    task automatic test_ar_stream();
        M_AXI_arready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            S_AXI_arvalid = (i < 8);
            S_AXI_araddr  = (i < 8) ? 16'(i * 4) : 16'hFFFF;
            sample();
            if (i < 8) begin
                checks++;
                if (S_AXI_arready !== 1'b1) begin errors++; $display("FAIL ar_stream_ready c%0d: got %b want 1", i, S_AXI_arready); end
            end
            if (i >= 1) begin
                checks++;
                if (M_AXI_arvalid !== 1'b1 || M_AXI_araddr !== 16'((i - 1) * 4)) begin
                    errors++; $display("FAIL ar_stream_out c%0d: got v=%b a=%h want v=1 a=%h", i, M_AXI_arvalid, M_AXI_araddr, 16'((i - 1) * 4));
                end
            end
            step();
        end
        S_AXI_arvalid = 1'b0;
        sample();
        checks++;
        if (M_AXI_arvalid !== 1'b0) begin errors++; $display("FAIL ar_stream_end: got %b want 0", M_AXI_arvalid); end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] beats [3];
        logic [31:0] got [$];
        logic        c_taken;
        beats[0] = 32'hAAAA_0001; beats[1] = 32'hBBBB_0002; beats[2] = 32'hCCCC_0003;
        M_AXI_wready = 1'b0;
        S_AXI_wstrb  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            S_AXI_wvalid = 1'b1; S_AXI_wdata = beats[i];
            sample();
            checks++;
            if (S_AXI_wready !== (i < 2) || (i > 0 && M_AXI_wdata !== beats[0])) begin
                errors++; $display("FAIL bp_fill c%0d: got rdy=%b out=%h want rdy=%b out=%h", i, S_AXI_wready, M_AXI_wdata, i < 2, beats[0]);
            end
            step();
        end
        // cycle 3: C still held upstream, then release the slave
        sample();
        checks++;
        if (S_AXI_wready !== 1'b0 || M_AXI_wvalid !== 1'b1 || M_AXI_wdata !== beats[0]) begin
            errors++; $display("FAIL bp_hold: got rdy=%b v=%b out=%h want rdy=0 v=1 out=%h", S_AXI_wready, M_AXI_wvalid, M_AXI_wdata, beats[0]);
        end
        M_AXI_wready = 1'b1;
        c_taken = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) sample();
            if (S_AXI_wvalid && S_AXI_wready) c_taken = 1'b1;
            if (M_AXI_wvalid) got.push_back(M_AXI_wdata);
            step();
            if (c_taken) S_AXI_wvalid = 1'b0;
        end
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL bp_count: got %0d beats want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== beats[i]) begin errors++; $display("FAIL bp_order beat%0d: got %h want %h", i, got[i], beats[i]); end
            end
        end
        S_AXI_wvalid = 1'b0;
    endtask

    task automatic test_stability();
        S_AXI_rready = 1'b0;
        M_AXI_rvalid = 1'b1; M_AXI_rdata = 32'h1234_5678; M_AXI_rresp = 2'b00;
        step();
        M_AXI_rvalid = 1'b0; M_AXI_rdata = 32'h0BAD_0BAD; M_AXI_rresp = 2'b10;
        for (int i = 0; i < 5; i++) begin
            sample();
            checks++;
            if (S_AXI_rvalid !== 1'b1 || S_AXI_rdata !== 32'h1234_5678 || S_AXI_rresp !== 2'b00) begin
                errors++; $display("FAIL r_stable c%0d: got v=%b d=%h r=%b want v=1 d=12345678 r=00", i, S_AXI_rvalid, S_AXI_rdata, S_AXI_rresp);
            end
            step();
        end
        S_AXI_rready = 1'b1;
        step();
        sample();
        checks++;
        if (S_AXI_rvalid !== 1'b0) begin errors++; $display("FAIL r_release: got %b want 0", S_AXI_rvalid); end
        step();
    endtask

    task automatic test_independence();
        logic [15:0] prev;
        prev = 16'd0;
        M_AXI_awready = 1'b0;
        M_AXI_arready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            S_AXI_awvalid = 1'b1; S_AXI_awaddr = 16'($urandom);
            S_AXI_arvalid = 1'b1; S_AXI_araddr = a;
            sample();
            checks++;
            if (S_AXI_arready !== 1'b1) begin errors++; $display("FAIL indep_arready c%0d: got %b want 1", i, S_AXI_arready); end
            if (i >= 1) begin
                checks++;
                if (M_AXI_arvalid !== 1'b1 || M_AXI_araddr !== prev) begin
                    errors++; $display("FAIL indep_ar c%0d: got v=%b a=%h want v=1 a=%h", i, M_AXI_arvalid, M_AXI_araddr, prev);
                end
            end
            if (i >= 2) begin
                checks++;
                if (S_AXI_awready !== 1'b0) begin errors++; $display("FAIL indep_aw_stall c%0d: got %b want 0", i, S_AXI_awready); end
            end
            prev = a;
            step();
        end
        S_AXI_awvalid = 1'b0; S_AXI_arvalid = 1'b0; M_AXI_awready = 1'b1;
        step(); step(); step();
        sample();
        checks++;
        if (M_AXI_awvalid !== 1'b0 || M_AXI_arvalid !== 1'b0) begin
            errors++; $display("FAIL indep_drain: got awv=%b arv=%b want 0 0", M_AXI_awvalid, M_AXI_arvalid);
        end
        step();
    endtask

    task automatic test_reset_mid();
        M_AXI_awready = 1'b0;
        S_AXI_awvalid = 1'b1; S_AXI_awaddr = 16'h1111;
        step();
        S_AXI_awaddr = 16'h2222;
        step();
        S_AXI_awvalid = 1'b0;
        #1;
        checks++;
        if (S_AXI_awready !== 1'b0 || M_AXI_awvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_full: got rdy=%b v=%b want rdy=0 v=1", S_AXI_awready, M_AXI_awvalid);
        end
        arst_n = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs_vld(c) !== 1'b0 || obs_rdy(c) !== 1'b1) begin
                errors++; $display("FAIL rstmid_async ch%0d: got v=%b rdy=%b want v=0 rdy=1", c, obs_vld(c), obs_rdy(c));
            end
        end
        step();
        arst_n = 1'b1;
        M_AXI_awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if (M_AXI_awvalid !== 1'b0) begin errors++; $display("FAIL rstmid_stale c%0d: got %b want 0", i, M_AXI_awvalid); end
            step();
        end
    endtask

    task automatic test_random_all();
        logic        iv [5];
        logic        orr [5];
        logic [63:0] id [5];
        for (int c = 0; c < 5; c++) mq[c].delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < 5; c++) begin
                iv[c]  = ($urandom % 4) != 0;
                orr[c] = ($urandom % 3) != 0;
                id[c]  = {$urandom, $urandom} & ((64'd1 << ch_width[c]) - 64'd1);
                drive(c, iv[c], id[c], orr[c]);
            end
            sample();
            for (int c = 0; c < 5; c++) begin
                int held;
                held = mq[c].size();
                checks++;
                if (obs_vld(c) !== (held > 0)) begin
                    errors++; $display("FAIL rand_valid ch%0d cyc%0d: got %b want %b", c, cyc, obs_vld(c), held > 0);
                end
                checks++;
                if (obs_rdy(c) !== (held < 2)) begin
                    errors++; $display("FAIL rand_ready ch%0d cyc%0d: got %b want %b", c, cyc, obs_rdy(c), held < 2);
                end
                if (held > 0) begin
                    checks++;
                    if (obs_dat(c) !== mq[c][0]) begin
                        errors++; $display("FAIL rand_data ch%0d cyc%0d: got %h want %h", c, cyc, obs_dat(c), mq[c][0]);
                    end
                end
                if (held > 0 && orr[c]) void'(mq[c].pop_front());
                if (iv[c] && held < 2) mq[c].push_back(id[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        idle_inputs();
        test_single_write();
        idle_inputs();
        test_ar_stream();
        idle_inputs();
        test_backpressure();
        idle_inputs();
        test_stability();
        idle_inputs();
        test_independence();
        idle_inputs();
        test_reset_mid();
        idle_inputs();
        test_random_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
